// File: rtl/synch_fifo_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : synch_fifo_gen2                                               |
// | Purpose  : Parametrised single-clock FIFO with threshold flags, optional |
// |            FWFT read mode, synchronous flush and sticky error flags.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module synch_fifo_gen2 #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        read_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     full_nxt,
  output logic                     empty_nxt,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   room_avail,
  output logic [$clog2(DEPTH):0]   data_avail,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;
  logic              wr_acc;
  logic              rd_acc;

  assign data_avail = count;

  // Acceptance is judged on the registered flags only, so a full FIFO can
  // still take a read and an empty FIFO can still take a write.
  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    count_nxt = count;
    if (reset || flush)
      count_nxt = '0;
    else if (wr_acc && !rd_acc)
      count_nxt = count + CNT_ONE;
    else if (rd_acc && !wr_acc)
      count_nxt = count - CNT_ONE;
    full_nxt  = (count_nxt == DEPTH_C);
    empty_nxt = (count_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      room_avail   <= DEPTH_C;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_nxt;
      full         <= full_nxt;
      empty        <= empty_nxt;
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      room_avail   <= DEPTH_C - count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        // A new error event outranks a clear in the same cycle.
        overflow  <= (overflow  && !clr_err) || (wr_en && full);
        underflow <= (underflow && !clr_err) || (rd_en && empty);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_acc)
      mem[wr_ptr] <= write_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign read_data = mem[rd_ptr];
      assign rd_valid  = !empty;
    end else begin : g_reg
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (flush) begin
          rd_valid_q <= 1'b0;
        end else if (rd_acc) begin
          rd_data_q  <= mem[rd_ptr];
          rd_valid_q <= 1'b1;
        end else begin
          rd_valid_q <= 1'b0;
        end
      end

      assign read_data = rd_data_q;
      assign rd_valid  = rd_valid_q;
    end
  endgenerate

endmodule
`default_nettype wire
